// File: rtl/disp_seq_ctrl_if.sv
// Key and status bundle between the push-button side and the picture-pipeline sequencer.
// The sequencer takes the slave view; the button/display side takes the master view.
interface disp_seq_ctrl_if;
    logic [3:0] keyin;
    logic [9:0] data_cnt;
    logic       wrap;
    logic [1:0] pic_mode;
    logic       mode_chg;
    logic       running;
    logic       auto_en;

    modport master (
        output keyin,
        input  data_cnt, wrap, pic_mode, mode_chg, running, auto_en
    );

    modport slave (
        input  keyin,
        output data_cnt, wrap, pic_mode, mode_chg, running, auto_en
    );
endinterface

// File: rtl/disp_seq_ctrl.sv
// Run/pause/single-step control of the vga_pic data_cnt timebase, plus manual or
// dwell-timed automatic rotation of the picture mode. Everything is clocked by clk1.
module disp_seq_ctrl #(
    parameter int CNT_MAX   = 999,
    parameter int NUM_MODES = 4,
    parameter int DWELL     = 10
) (
    input  logic           clk1,
    input  logic           rstn,
    disp_seq_ctrl_if.slave bus
);
    localparam logic [9:0] CNT_LAST   = 10'(CNT_MAX);
    localparam logic [9:0] DWELL_LAST = 10'(DWELL - 1);
    localparam logic [1:0] MODE_LAST  = 2'(NUM_MODES - 1);

    typedef enum logic {S_RUN, S_PAUSE} run_state_e;

    run_state_e state_q;
    logic [3:0] sync1_q, sync2_q, prev_q, press;
    logic [9:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic [1:0] mode_q, mode_d;
    logic       wrap_q, wrap_d, mode_chg_q, running_q, auto_q;
    logic       run_next, step, cnt_inc, dwell_en, dwell_exp, mode_adv;

    assign press     = prev_q & ~sync2_q;
    // The counter follows the state being entered, so a pause edge never increments.
    assign run_next  = (state_q == S_RUN) ^ press[0];
    assign step      = (state_q == S_PAUSE) & press[1] & ~press[0];
    assign cnt_inc   = run_next | step;
    assign dwell_en  = auto_q & (state_q == S_RUN);
    assign dwell_exp = dwell_en & (dwell_q >= DWELL_LAST);
    // A coincident auto/manual toggle suppresses the expiry advance.
    assign mode_adv  = press[2] | (dwell_exp & ~press[3]);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (cnt_inc) begin
            if (cnt_q >= CNT_LAST) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
        end

        dwell_d = dwell_q;
        if (press[2] | press[3] | dwell_exp) begin
            dwell_d = '0;
        end else if (dwell_en) begin
            dwell_d = dwell_q + 10'd1;
        end

        mode_d = mode_q;
        if (mode_adv) begin
            mode_d = (mode_q >= MODE_LAST) ? 2'd0 : mode_q + 2'd1;
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            prev_q     <= '1;
            state_q    <= S_RUN;
            running_q  <= 1'b1;
            auto_q     <= 1'b0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            dwell_q    <= '0;
            mode_q     <= '0;
            mode_chg_q <= 1'b0;
        end else begin
            sync1_q <= bus.keyin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (press[0]) begin
                state_q <= (state_q == S_RUN) ? S_PAUSE : S_RUN;
            end
            running_q  <= run_next;
            auto_q     <= auto_q ^ press[3];
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            dwell_q    <= dwell_d;
            mode_q     <= mode_d;
            mode_chg_q <= (mode_d != mode_q);
        end
    end

    assign bus.data_cnt = cnt_q;
    assign bus.wrap     = wrap_q;
    assign bus.pic_mode = mode_q;
    assign bus.mode_chg = mode_chg_q;
    assign bus.running  = running_q;
    assign bus.auto_en  = auto_q;
endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Bench for disp_seq_ctrl: vector table, hand-written corner sequences and random keys,
// all checked every cycle against a behavioural model of the sequencer.
module tb_disp_seq_ctrl;
    localparam int CNT_MAX   = 999;
    localparam int NUM_MODES = 4;
    localparam int DWELL     = 10;

    logic clk1 = 1'b0;
    logic rstn;

    disp_seq_ctrl_if bus();

    disp_seq_ctrl #(
        .CNT_MAX  (CNT_MAX),
        .NUM_MODES(NUM_MODES),
        .DWELL    (DWELL)
    ) dut (
        .clk1(clk1),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk1 = ~clk1;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int chg_seen = 0;

    // Behavioural model: key sample history plus the architectural state in plain integers.
    logic [3:0] kq[$];
    int m_cnt, m_mode, m_dwell;
    bit m_wrap, m_chg, m_run, m_auto;

    typedef struct {
        logic [3:0] key;
        int ticks;
        int cnt;
        int run;
        int mode;
        int chg;
        int aut;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".cnt"},  bus.data_cnt, 0);
        check({tag, ".wrap"}, bus.wrap,     0);
        check({tag, ".mode"}, bus.pic_mode, 0);
        check({tag, ".chg"},  bus.mode_chg, 0);
        check({tag, ".run"},  bus.running,  1);
        check({tag, ".auto"}, bus.auto_en,  0);
    endtask

    task automatic model_reset();
        kq      = {4'hF, 4'hF, 4'hF};
        m_cnt   = 0;
        m_mode  = 0;
        m_dwell = 0;
        m_wrap  = 0;
        m_chg   = 0;
        m_run   = 1;
        m_auto  = 0;
    endtask

    // A key sampled at edge n is acted upon at edge n+2: press = was-high & now-low.
    task automatic model_step(input logic [3:0] k);
        logic [3:0] p;
        bit run_n, stp, adv;
        int nm;
        p = kq[0] & ~kq[1];
        void'(kq.pop_front());
        kq.push_back(k);
        run_n  = m_run ^ p[0];
        stp    = !m_run && p[1] && !p[0];
        m_wrap = 0;
        if (run_n || stp) begin
            m_wrap = (m_cnt == CNT_MAX);
            m_cnt  = (m_cnt + 1) % (CNT_MAX + 1);
        end
        adv = p[2];
        if (p[2] || p[3]) begin
            m_dwell = 0;
        end else if (m_auto && m_run) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_dwell = 0;
                adv = 1;
            end
        end
        nm     = adv ? (m_mode + 1) % NUM_MODES : m_mode;
        m_chg  = (nm != m_mode);
        m_mode = nm;
        m_auto = m_auto ^ p[3];
        m_run  = run_n;
    endtask

    task automatic tick(input logic [3:0] k);
        bus.keyin = k;
        @(posedge clk1);
        model_step(k);
        @(negedge clk1);
        cyc++;
        if (bus.mode_chg) chg_seen++;
        n_tests++;
        if ({bus.data_cnt, bus.wrap, bus.pic_mode, bus.mode_chg, bus.running, bus.auto_en} !==
            {10'(m_cnt), m_wrap, 2'(m_mode), m_chg, m_run, m_auto}) begin
            n_fail++;
            $display("FAIL model cyc %0d: cnt %0d/%0d wrap %0b/%0b mode %0d/%0d chg %0b/%0b run %0b/%0b auto %0b/%0b",
                     cyc, bus.data_cnt, m_cnt, bus.wrap, m_wrap, bus.pic_mode, m_mode,
                     bus.mode_chg, m_chg, bus.running, m_run, bus.auto_en, m_auto);
        end
    endtask

    // One-cycle key pulse, then idle until the action has landed.
    task automatic press_key(input logic [3:0] k);
        tick(k);
        tick(4'hF);
        tick(4'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        //        key    ticks cnt run mode chg auto
        vt[0]  = '{4'hF, 4,    5,  1,  0,   0,  0};
        vt[1]  = '{4'hE, 3,    7,  0,  0,   0,  0};
        vt[2]  = '{4'hD, 3,    8,  0,  0,   0,  0};
        vt[3]  = '{4'hD, 3,    9,  0,  0,   0,  0};
        vt[4]  = '{4'hD, 3,    10, 0,  0,   0,  0};
        vt[5]  = '{4'hF, 10,   10, 0,  0,   0,  0};
        vt[6]  = '{4'hB, 3,    10, 0,  1,   1,  0};
        vt[7]  = '{4'hB, 3,    10, 0,  2,   1,  0};
        vt[8]  = '{4'hB, 3,    10, 0,  3,   1,  0};
        vt[9]  = '{4'hB, 3,    10, 0,  0,   1,  0};
        vt[10] = '{4'hC, 3,    11, 1,  0,   0,  0};
        vt[11] = '{4'hF, 5,    16, 1,  0,   0,  0};

        bus.keyin = 4'hF;
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check_reset("por");
        rstn = 1'b1;

        // Free run through one full period
        repeat (999) tick(4'hF);
        check("run.cnt999", bus.data_cnt, 999);
        check("run.nowrap", bus.wrap, 0);
        tick(4'hF);
        check("run.cnt0", bus.data_cnt, 0);
        check("run.wrap", bus.wrap, 1);
        tick(4'hF);
        check("run.cnt1", bus.data_cnt, 1);
        check("run.wrap1cyc", bus.wrap, 0);
        check("run.mode", bus.pic_mode, 0);
        check("run.running", bus.running, 1);

        // Pause, single step, manual mode, simultaneous toggle+step
        for (int i = 0; i < 12; i++) begin
            tick(vt[i].key);
            for (int j = 1; j < vt[i].ticks; j++) tick(4'hF);
            check($sformatf("vec%0d.cnt", i),  bus.data_cnt, vt[i].cnt);
            check($sformatf("vec%0d.run", i),  bus.running,  vt[i].run);
            check($sformatf("vec%0d.mode", i), bus.pic_mode, vt[i].mode);
            check($sformatf("vec%0d.chg", i),  bus.mode_chg, vt[i].chg);
            check($sformatf("vec%0d.auto", i), bus.auto_en,  vt[i].aut);
        end

        // Step across the wrap point while paused
        for (int i = 0; i < 1100 && m_cnt != 997; i++) tick(4'hF);
        check("p999.reach997", bus.data_cnt, 997);
        press_key(4'hE);
        check("p999.cnt", bus.data_cnt, 999);
        check("p999.run", bus.running, 0);
        press_key(4'hD);
        check("p999.stepcnt", bus.data_cnt, 0);
        check("p999.stepwrap", bus.wrap, 1);
        tick(4'hF);
        check("p999.hold", bus.data_cnt, 0);
        check("p999.wrapoff", bus.wrap, 0);
        press_key(4'hC);
        check("p999.both.run", bus.running, 1);

        // Auto rotation every DWELL cycles
        press_key(4'h7);
        check("auto.en", bus.auto_en, 1);
        check("auto.mode0", bus.pic_mode, 0);
        for (int a = 1; a <= 4; a++) begin
            repeat (DWELL - 1) tick(4'hF);
            check($sformatf("auto.hold%0d", a), bus.pic_mode, (a - 1) % NUM_MODES);
            tick(4'hF);
            check($sformatf("auto.adv%0d", a), bus.pic_mode, a % NUM_MODES);
            check($sformatf("auto.chg%0d", a), bus.mode_chg, 1);
        end
        repeat (4) tick(4'hF);
        press_key(4'hE);
        check("autop.run", bus.running, 0);
        repeat (20) tick(4'hF);
        check("autop.hold", bus.pic_mode, 0);
        press_key(4'hE);
        check("autop.resume", bus.running, 1);
        repeat (2) tick(4'hF);
        check("autop.left", bus.pic_mode, 0);
        tick(4'hF);
        check("autop.adv", bus.pic_mode, 1);
        check("autop.chg", bus.mode_chg, 1);

        // Next-mode press landing on dwell expiry: one advance, dwell restarts
        repeat (7) tick(4'hF);
        press_key(4'hB);
        check("coin2.mode", bus.pic_mode, 2);
        check("coin2.chg", bus.mode_chg, 1);
        repeat (DWELL - 1) tick(4'hF);
        check("coin2.hold", bus.pic_mode, 2);
        tick(4'hF);
        check("coin2.next", bus.pic_mode, 3);

        // Auto toggle landing on dwell expiry: no advance
        repeat (7) tick(4'hF);
        press_key(4'h7);
        check("coin3.mode", bus.pic_mode, 3);
        check("coin3.auto", bus.auto_en, 0);
        repeat (20) tick(4'hF);
        check("coin3.manual", bus.pic_mode, 3);

        // A held key gives exactly one press
        chg_seen = 0;
        repeat (50) tick(4'hB);
        repeat (3) tick(4'hF);
        check("hold.mode", bus.pic_mode, 0);
        check("hold.chgs", chg_seen, 1);

        // Asynchronous reset mid-operation
        press_key(4'hB);
        press_key(4'hB);
        press_key(4'h7);
        check("rst.pre.mode", bus.pic_mode, 2);
        check("rst.pre.auto", bus.auto_en, 1);
        repeat (5) tick(4'hF);
        rstn = 1'b0;
        #1;
        check_reset("async");
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rstn = 1'b1;
        model_reset();
        repeat (20) tick(4'hF);
        check("rst.post.cnt", bus.data_cnt, 20);
        check("rst.post.mode", bus.pic_mode, 0);
        check("rst.post.auto", bus.auto_en, 0);
        check("rst.post.run", bus.running, 1);

        // Random key activity against the model
        repeat (3000) begin
            logic [3:0] k;
            k = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            tick(k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/disp_seq_ctrl.md
# disp_seq_ctrl

Key-driven sequencer for the LCD picture pipeline, clocked by the slow divided clock `clk1`. It owns the `data_cnt` timebase consumed by `vga_pic`: run, pause and single-step control of the 0..CNT_MAX counter. It also schedules the active picture mode, either stepped manually or rotated automatically after a fixed dwell. It sits between the push-buttons and `vga_pic`, replacing the free-running counter in the top level.

## Interface
Parameters:
- CNT_MAX, 999: terminal value of `data_cnt`; legal range 1..1023.
- NUM_MODES, 4: number of picture modes; legal range 1..4.
- DWELL, 10: `clk1` cycles spent in each mode during auto rotation; legal range 1..1023.

Ports:
- clk1  in  1: slow timebase clock; all state updates on its rising edge.
- rstn  in  1: reset, asynchronous, active-low; clock clk1.
- keyin  in  4: raw buttons, active-low. [0] = run/pause toggle, [1] = single step, [2] = next mode, [3] = auto/manual toggle.
- data_cnt  out  10: timebase value, 0..CNT_MAX.
- wrap  out  1: one-cycle pulse in the cycle `data_cnt` returns to 0 from CNT_MAX.
- pic_mode  out  2: active picture mode, 0..NUM_MODES-1.
- mode_chg  out  1: one-cycle pulse in the first cycle a new `pic_mode` value is presented.
- running  out  1: 1 = RUN, 0 = PAUSE.
- auto_en  out  1: 1 = auto mode rotation enabled.

## Operation
- Key conditioning, per bit:
  - 2-flop synchronizer, then a previous-sample flop.
  - press[i] = prev[i] & ~sync[i], asserted for one cycle per falling edge.
  - All three flops reset to 1, so no press is detected out of reset.
  - A held key produces exactly one press.
- Run state machine, two states:
  - RUN (reset state): `data_cnt` +1 per cycle. At CNT_MAX the next value is 0 and `wrap` = 1 for that cycle.
  - PAUSE: `data_cnt` holds.
  - press[0] toggles RUN <-> PAUSE.
  - press[1] in PAUSE advances `data_cnt` by one with the same wrap rule, and pulses `wrap` if it wraps.
  - press[1] in RUN is ignored.
  - press[0] and press[1] in the same cycle: press[0] wins and the step is discarded.
- Mode scheduler:
  - Next mode is (pic_mode+1) mod NUM_MODES. With NUM_MODES = 1, `pic_mode` stays 0 and `mode_chg` never fires.
  - press[2] advances the mode in either auto or manual, and clears the dwell counter.
  - press[3] toggles `auto_en` and clears the dwell counter.
  - When `auto_en` = 1 and in RUN, the dwell counter increments each cycle. At DWELL-1 it advances the mode and returns to 0.
  - In PAUSE or manual, the dwell counter holds.
  - press[2] coinciding with dwell expiry gives a single advance and dwell = 0.
  - press[3] coinciding with dwell expiry: the toggle applies, dwell is cleared and no advance happens.
- `mode_chg` is registered and is high exactly when `pic_mode` differs from its previous-cycle value.

## Timing
- Reset values: data_cnt 0, wrap 0, pic_mode 0, mode_chg 0, running 1, auto_en 0, dwell 0, key flops all 1.
- Reset is asynchronous and may assert mid-operation; all state returns to reset values immediately.
- Key latency: keyin[i] is first sampled low at edge E. press[i] is high between E+1 and E+2. The action is visible after edge E+2.
- `data_cnt`, `wrap`, `pic_mode`, `mode_chg`, `running` and `auto_en` are all registered; there are no combinational paths from `keyin` to outputs.
- RUN/PAUSE takes effect on the same edge as the toggle. The first held value in PAUSE is the value present after that edge; the counter does not increment on that edge.
- Counter and dwell arithmetic are compare-and-clear, never rely on power-of-two overflow. The counter is 10 bits wide and `pic_mode` is 2 bits wide.

## Test plan
- Reset, then 1000 free-running cycles -> data_cnt runs 0..999, then reads 0 with `wrap` high for exactly one cycle. pic_mode stays 0 and running stays 1.
- Pulse keyin[0] low at data_cnt = 5 (ordering per Timing) -> data_cnt freezes at 7. Three keyin[1] presses -> data_cnt reads 8, 9, 10. A fourth press of keyin[0] resumes counting.
- In PAUSE at data_cnt = 999, press keyin[1] -> data_cnt = 0 and `wrap` pulses once. Press keyin[0] and keyin[1] together -> running = 1 with no step.
- Press keyin[3] with DWELL = 10 -> auto_en = 1 and pic_mode advances 0->1->2->3->0 every 10 cycles, with a `mode_chg` pulse on each advance. While paused, the mode holds and dwell resumes where it stopped.
- Press keyin[2] four times in manual mode -> pic_mode 1, 2, 3, 0 with four `mode_chg` pulses. Holding keyin[2] low for 50 cycles yields exactly one advance.
- Assert rstn low mid-count with pic_mode = 2 and auto_en = 1 -> all outputs return to reset values immediately, and no spurious press occurs after release with keys idle high.
